// File: rtl/apb_periph_bridge_pkg.sv
// apb_periph_bridge_pkg: shared states, constants and helpers for the APB peripheral bridge
package apb_periph_bridge_pkg;
  localparam int PERIPH_ADDR_W = 5;
  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, WAIT, DONE} state_e;
  function automatic logic [31:0] merge(input logic [3:0] strb, input logic [31:0] nw, input logic [31:0] old);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k+:8] = strb[k] ? nw[8*k+:8] : old[8*k+:8];
    return r;
  endfunction
  function automatic logic legal(input logic [31:0] addr, input int reg_top);
    return addr[1:0] == 2'b0 && addr[31:5] == 27'b0 && 32'(addr[4:0]) <= $unsigned(reg_top);
  endfunction
endpackage

// File: rtl/apb_periph_bridge_if.sv
// apb_periph_bridge_if: APB completer-side bus bundle
interface apb_periph_bridge_if #(parameter int PADDR_W = 12);
  logic [PADDR_W-1:0] paddr;
  logic psel, penable, pwrite;
  logic [31:0] pwdata, prdata;
  logic [3:0] pstrb;
  logic pready, pslverr;
  modport master (output paddr, psel, penable, pwrite, pwdata, pstrb, input prdata, pready, pslverr);
  modport slave (input paddr, psel, penable, pwrite, pwdata, pstrb, output prdata, pready, pslverr);
endinterface

// File: rtl/apb_periph_bridge.sv
// apb_periph_bridge: APB to byte-addressed register strobe bridge with RMW for partial writes.
// Define APB_PSLVERR_EN to report illegal accesses on pslverr; otherwise they are silent no-ops.
module apb_periph_bridge import apb_periph_bridge_pkg::*; #(
  parameter int PADDR_W = 12,
  parameter int REG_TOP = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  apb_periph_bridge_if.slave apb,
  output logic write_o,
  output logic [3:0] data_be_o,
  output logic [PERIPH_ADDR_W-1:0] addr_o,
  output logic [31:0] wdata_o,
  input  logic [31:0] rdata_i
);
  localparam state_e POST = WAIT_STATES == 0 ? DONE : WAIT;
  state_e state_q, state_d;
  logic [PERIPH_ADDR_W-1:0] addr_q, addr_d;
  logic wr_q, wr_d, err_q, err_d, write_q, write_d, pready_q, pready_d, pslverr_q, pslverr_d;
  logic [31:0] pw_q, pw_d, rbuf_q, rbuf_d, wd_q, wd_d, prdata_q, prdata_d;
  logic [3:0] strb_q, strb_d, be_q, be_d, cnt_q, cnt_d;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wr_d = wr_q;
    pw_d = pw_q;
    strb_d = strb_q;
    err_d = err_q;
    rbuf_d = rbuf_q;
    wd_d = wd_q;
    cnt_d = state_q == WAIT ? cnt_q + 4'd1 : 4'd0;
    unique case (state_q)
      IDLE: if (apb.psel && !apb.penable) begin
        addr_d = apb.paddr[PERIPH_ADDR_W-1:0];
        wr_d = apb.pwrite;
        pw_d = apb.pwdata;
        strb_d = apb.pstrb;
        err_d = !legal(32'(apb.paddr), REG_TOP);
        wd_d = apb.pwdata;
        state_d = (err_d || (apb.pwrite && apb.pstrb == 4'h0)) ? POST :
                  !apb.pwrite ? RD : apb.pstrb == 4'hF ? WR : RMW_RD;
      end
      RD: begin
        rbuf_d = rdata_i;
        state_d = POST;
      end
      RMW_RD: begin
        wd_d = merge(strb_q, pw_q, rdata_i);
        state_d = WR;
      end
      WR: state_d = POST;
      WAIT: state_d = cnt_q == 4'(WAIT_STATES - 1) ? DONE : WAIT;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A dropped psel mid-transfer abandons it; no further strobes follow.
    if (state_q != IDLE && !apb.psel) state_d = IDLE;
    write_d = state_d == WR;
    be_d = (state_d == RD || state_d == RMW_RD) ? 4'hF : 4'h0;
    pready_d = state_d == DONE;
    prdata_d = (state_d == DONE && !wr_d && !err_d) ? rbuf_d : 32'h0;
`ifdef APB_PSLVERR_EN
    pslverr_d = state_d == DONE && err_d;
`else
    pslverr_d = 1'b0;
`endif
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q <= '0;
      wr_q <= 1'b0;
      pw_q <= '0;
      strb_q <= '0;
      err_q <= 1'b0;
      rbuf_q <= '0;
      wd_q <= '0;
      cnt_q <= '0;
      write_q <= 1'b0;
      be_q <= '0;
      pready_q <= 1'b0;
      prdata_q <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wr_q <= wr_d;
      pw_q <= pw_d;
      strb_q <= strb_d;
      err_q <= err_d;
      rbuf_q <= rbuf_d;
      wd_q <= wd_d;
      cnt_q <= cnt_d;
      write_q <= write_d;
      be_q <= be_d;
      pready_q <= pready_d;
      prdata_q <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end
  assign write_o = write_q;
  assign data_be_o = be_q;
  assign addr_o = addr_q;
  assign wdata_o = wd_q;
  assign apb.prdata = prdata_q;
  assign apb.pready = pready_q;
  assign apb.pslverr = pslverr_q;
endmodule

// File: tb/tb_apb_periph_bridge.sv
// tb_apb_periph_bridge: directed checks of the APB peripheral bridge (zero and three wait states)
module tb_apb_periph_bridge;
`ifdef APB_PSLVERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  apb_periph_bridge_if #(.PADDR_W(12)) a0 ();
  apb_periph_bridge_if #(.PADDR_W(12)) a3 ();
  logic w0, w3;
  logic [3:0] be0, be3;
  logic [4:0] ao0, ao3;
  logic [31:0] wd0, wd3, rd0, rd3;
  logic [4:0] stub_addr = 5'h0;
  logic [31:0] stub_val = 32'h0;
  assign rd0 = (ao0 == stub_addr && be0 == 4'hF) ? stub_val : 32'hDEAD_BEEF;
  assign rd3 = (ao3 == stub_addr && be3 == 4'hF) ? stub_val : 32'hDEAD_BEEF;
  assign a3.paddr = a0.paddr;
  assign a3.psel = a0.psel;
  assign a3.penable = a0.penable;
  assign a3.pwrite = a0.pwrite;
  assign a3.pwdata = a0.pwdata;
  assign a3.pstrb = a0.pstrb;
  apb_periph_bridge #(.PADDR_W(12), .REG_TOP(16), .WAIT_STATES(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .apb(a0.slave), .write_o(w0), .data_be_o(be0),
    .addr_o(ao0), .wdata_o(wd0), .rdata_i(rd0));
  apb_periph_bridge #(.PADDR_W(12), .REG_TOP(16), .WAIT_STATES(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .apb(a3.slave), .write_o(w3), .data_be_o(be3),
    .addr_o(ao3), .wdata_o(wd3), .rdata_i(rd3));
  int wr_cnt = 0;
  logic [31:0] wd_seen = 32'h0;
  logic [4:0] wa_seen = 5'h0, rd_addr = 5'h0;
  always @(negedge clk) begin
    if (w0) begin
      wr_cnt++;
      wd_seen = wd0;
      wa_seen = ao0;
    end
    if (be0 == 4'hF) rd_addr = ao0;
  end
  int checks = 0, failures = 0;
  int lat, wbase;
  logic [31:0] prd;
  logic perr;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic xfer(input bit sel, input logic [11:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
    wbase = wr_cnt;
    @(posedge clk); #1;
    a0.psel = 1'b1; a0.penable = 1'b0; a0.paddr = a; a0.pwrite = w; a0.pwdata = d; a0.pstrb = s;
    @(posedge clk); #1;
    a0.penable = 1'b1;
    lat = 1;
    while (1) begin
      @(negedge clk);
      if (sel ? a3.pready : a0.pready) break;
      if (lat >= 40) break;
      @(posedge clk); #1;
      lat++;
    end
    prd = sel ? a3.prdata : a0.prdata;
    perr = sel ? a3.pslverr : a0.pslverr;
    @(posedge clk); #1;
    a0.psel = 1'b0; a0.penable = 1'b0;
  endtask
  initial begin
    a0.psel = 1'b0; a0.penable = 1'b0; a0.paddr = '0; a0.pwrite = 1'b0; a0.pwdata = '0; a0.pstrb = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_write", 32'(w0), 32'h0);
    check("rst_be_addr", {23'h0, be0, ao0}, 32'h0);
    check("rst_wdata", wd0, 32'h0);
    check("rst_apb", {a0.prdata[30:0], a0.pready}, 32'h0);
    check("rst_pslverr", 32'(a0.pslverr), 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    stub_addr = 5'h04; stub_val = 32'h0000_0055;
    xfer(0, 12'h004, 1'b0, 32'h0, 4'hF);
    check("rd_lat", lat, 2);
    check("rd_data", prd, 32'h55);
    check("rd_err", 32'(perr), 32'h0);
    check("rd_addr", 32'(rd_addr), 32'h04);
    check("rd_nowrite", wr_cnt - wbase, 0);
    xfer(0, 12'h00C, 1'b1, 32'hA1B2_C3D4, 4'hF);
    check("wr_lat", lat, 2);
    check("wr_pulses", wr_cnt - wbase, 1);
    check("wr_data", wd_seen, 32'hA1B2_C3D4);
    check("wr_addr", 32'(wa_seen), 32'h0C);
    check("wr_prdata", prd, 32'h0);
    stub_addr = 5'h0C; stub_val = 32'h1122_3344;
    xfer(0, 12'h00C, 1'b1, 32'h0000_00EE, 4'b0001);
    check("rmw_lat", lat, 3);
    check("rmw_pulses", wr_cnt - wbase, 1);
    check("rmw_data", wd_seen, 32'h1122_33EE);
    check("rmw_rdaddr", 32'(rd_addr), 32'h0C);
    stub_addr = 5'h14; stub_val = 32'h7777_7777;
    xfer(0, 12'h014, 1'b1, 32'hFFFF_FFFF, 4'hF);
    check("oor_lat", lat, 1);
    check("oor_nowrite", wr_cnt - wbase, 0);
    check("oor_err", 32'(perr), 32'(ERR_EN));
    stub_addr = 5'h00;
    xfer(0, 12'h002, 1'b0, 32'h0, 4'hF);
    check("mis_lat", lat, 1);
    check("mis_err", 32'(perr), 32'(ERR_EN));
    check("mis_data", prd, 32'h0);
    stub_addr = 5'h04; stub_val = 32'h0000_0099;
    xfer(0, 12'h104, 1'b0, 32'h0, 4'hF);
    check("hi_err", 32'(perr), 32'(ERR_EN));
    check("hi_data", prd, 32'h0);
    xfer(0, 12'h008, 1'b1, 32'h1234_5678, 4'h0);
    check("noop_lat", lat, 1);
    check("noop_nowrite", wr_cnt - wbase, 0);
    check("noop_err", 32'(perr), 32'h0);
    stub_addr = 5'h10; stub_val = 32'hCAFE_0010;
    xfer(1, 12'h010, 1'b0, 32'h0, 4'hF);
    check("ws3_lat", lat, 5);
    check("ws3_data", prd, 32'hCAFE_0010);
    stub_addr = 5'h0C; stub_val = 32'h5555_5555;
    wbase = wr_cnt;
    @(posedge clk); #1;
    a0.psel = 1'b1; a0.penable = 1'b0; a0.paddr = 12'h00C; a0.pwrite = 1'b1; a0.pwdata = 32'hAA; a0.pstrb = 4'b0001;
    @(posedge clk); #1;
    a0.penable = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstmid_write", 32'(w0), 32'h0);
    check("rstmid_be_addr", {23'h0, be0, ao0}, 32'h0);
    check("rstmid_wdata", wd0, 32'h0);
    check("rstmid_apb", {a0.prdata[30:0], a0.pready}, 32'h0);
    rst = 1'b0; a0.psel = 1'b0; a0.penable = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rstmid_nowrite", wr_cnt - wbase, 0);
    stub_addr = 5'h08; stub_val = 32'h0BAD_F00D;
    xfer(0, 12'h008, 1'b0, 32'h0, 4'hF);
    check("post_lat", lat, 2);
    check("post_data", prd, 32'h0BAD_F00D);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
